// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared state enum, default sizes and lane/offset/index helpers for data_mem_sync
package data_mem_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DEPTH = 64;
  typedef enum logic {CLEAR, READY} state_t;
  function automatic int lanes_of(input int dw);
    return dw / 8;
  endfunction
  function automatic int off_of(input int dw);
    return $clog2(dw / 8);
  endfunction
  function automatic int idx_of(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/data_mem_sync_if.sv
// data_mem_sync_if: request/response bundle; master = requester, slave = data_mem_sync
interface data_mem_sync_if import data_mem_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic req_valid;
  logic req_ready;
  logic mem_write;
  logic mem_read;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH/8-1:0] byte_en;
  logic [DATA_WIDTH-1:0] read_data;
  logic read_valid;
  logic err;
  modport master(
    output req_valid, mem_write, mem_read, addr, write_data, byte_en,
    input req_ready, read_data, read_valid, err
  );
  modport slave(
    input req_valid, mem_write, mem_read, addr, write_data, byte_en,
    output req_ready, read_data, read_valid, err
  );
endinterface

// File: rtl/data_mem_clear_ctrl.sv
// data_mem_clear_ctrl: post-reset clear FSM; ports clk, reset, ready (req_ready), clr_we/clr_idx (zeroing write)
module data_mem_clear_ctrl import data_mem_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic reset,
  output logic ready,
  output logic clr_we,
  output logic [$clog2(DEPTH)-1:0] clr_idx
);
  localparam int IDX = idx_of(DEPTH);
  state_t state, state_nx;
  logic [IDX-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == CLEAR ? cnt + 1'b1 : cnt;
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == CLEAR && cnt == IDX'(DEPTH - 1)) ? READY : state;
    ready = state == READY;
    clr_we = state == CLEAR;
    clr_idx = cnt;
  end
endmodule

// File: rtl/data_mem_sync.sv
// data_mem_sync: cleared-on-reset data memory, 1-cycle reads, err on bad address; ports clk, reset, bus (slave); DATA_MEM_BYTE_WRITE_EN enables byte strobes
module data_mem_sync import data_mem_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic clk,
  input logic reset,
  data_mem_sync_if.slave bus
);
  localparam int LANES = lanes_of(DATA_WIDTH);
  localparam int OFF = off_of(DATA_WIDTH);
  localparam int IDX = idx_of(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic ready, clr_we, acc, bad, good_rd, good_wr;
  logic [IDX-1:0] clr_idx, idx;
  logic [DATA_WIDTH-1:0] mask;
  data_mem_clear_ctrl #(.DEPTH(DEPTH)) u_clr (
    .clk(clk),
    .reset(reset),
    .ready(ready),
    .clr_we(clr_we),
    .clr_idx(clr_idx)
  );
  assign bus.req_ready = ready;
  always_comb begin
    acc = bus.req_valid & ready & (bus.mem_read | bus.mem_write);
    idx = bus.addr[OFF +: IDX];
    bad = ((bus.addr & ADDR_WIDTH'(LANES - 1)) != '0) | ((bus.addr >> (OFF + IDX)) != '0);
    good_rd = acc & ~bad & bus.mem_read;
    good_wr = acc & ~bad & bus.mem_write;
  end
`ifdef DATA_MEM_BYTE_WRITE_EN
  always_comb begin
    mask = '0;
    for (int i = 0; i < LANES; i++) mask[8*i +: 8] = {8{bus.byte_en[i]}};
  end
`else
  logic unused_be;
  assign unused_be = ^bus.byte_en;
  assign mask = '1;
`endif
  always_ff @(posedge clk) begin
    if (!reset && clr_we) mem[clr_idx] <= '0;
    else if (!reset && good_wr) mem[idx] <= (mem[idx] & ~mask) | (bus.write_data & mask);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.read_data <= '0;
      bus.read_valid <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.read_valid <= good_rd;
      bus.err <= acc & bad;
      if (good_rd) bus.read_data <= mem[idx];
    end
  end
endmodule

// File: tb/tb_data_mem_sync.sv
// tb_data_mem_sync: directed plan plus random traffic checked against an array-based memory model
module tb_data_mem_sync;
  import data_mem_pkg::*;
`ifdef DATA_MEM_BYTE_WRITE_EN
  localparam bit BE_ON = 1'b1;
`else
  localparam bit BE_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int pass_cnt = 0;
  int total_cnt = 0;
  data_mem_sync_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  data_mem_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask
  logic [31:0] mm [64];
  logic [31:0] rd_m = '0;
  bit rv_m = 0, err_m = 0, ready_m = 0, started = 0;
  int ccnt = 0;
  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      ready_m = 0;
      ccnt = 0;
      rv_m = 0;
      err_m = 0;
      rd_m = '0;
      foreach (mm[i]) mm[i] = '0;
    end else begin
      bit acc, bad;
      acc = bus.req_valid && ready_m && (bus.mem_read || bus.mem_write);
      bad = (bus.addr % 4 != 0) || (bus.addr >= 256);
      rv_m = 0;
      err_m = 0;
      if (acc && bad) err_m = 1;
      else if (acc) begin
        if (bus.mem_read) begin
          rd_m = mm[bus.addr / 4];
          rv_m = 1;
        end
        if (bus.mem_write)
          for (int l = 0; l < 4; l++)
            if (!BE_ON || bus.byte_en[l]) mm[bus.addr / 4][8*l +: 8] = bus.write_data[8*l +: 8];
      end
      if (!ready_m) begin
        ccnt++;
        if (ccnt == 64) ready_m = 1;
      end
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", {31'b0, bus.req_ready}, {31'b0, ready_m});
      chk("read_valid", {31'b0, bus.read_valid}, {31'b0, rv_m});
      chk("err", {31'b0, bus.err}, {31'b0, err_m});
      chk("read_data", bus.read_data, rd_m);
      if (bus.err && bus.read_valid) chk("err_rv_exclusive", 32'd1, 32'd0);
    end
  end
  task automatic idle();
    bus.req_valid = 0;
    bus.mem_read = 0;
    bus.mem_write = 0;
    bus.addr = '0;
    bus.write_data = '0;
    bus.byte_en = '0;
  endtask
  task automatic req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    bus.req_valid = 1;
    bus.mem_write = wr;
    bus.mem_read = rd;
    bus.addr = a;
    bus.write_data = wd;
    bus.byte_en = be;
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, n, 64);
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk("reset_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("reset_read_data", bus.read_data, 32'd0);
    wait_ready("clear_cycles");
    req(0, 1, 100, 0, 0);
    chk("rd100_valid", {31'b0, bus.read_valid}, 32'd1);
    chk("rd100_data", bus.read_data, 32'd0);
    req(1, 0, 8, 200, 4'hF);
    req(0, 1, 8, 0, 0);
    chk("rd8_data", bus.read_data, 32'd200);
    chk("rd8_valid", {31'b0, bus.read_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("rd8_valid_pulse", {31'b0, bus.read_valid}, 32'd0);
    req(1, 0, 12, 32'h11223344, 4'hF);
    req(1, 0, 12, 32'hAABBCCDD, 4'b0010);
    req(0, 1, 12, 0, 0);
    chk("byte_write", bus.read_data, BE_ON ? 32'h1122CC44 : 32'hAABBCCDD);
    req(1, 0, 6, 32'hFF, 4'hF);
    chk("mis_err", {31'b0, bus.err}, 32'd1);
    chk("mis_rv", {31'b0, bus.read_valid}, 32'd0);
    req(0, 1, 4, 0, 0);
    chk("word1_unchanged", bus.read_data, 32'd0);
    req(0, 1, 8, 0, 0);
    req(0, 1, 256, 0, 0);
    chk("oor_err", {31'b0, bus.err}, 32'd1);
    chk("oor_hold", bus.read_data, 32'd200);
    req(1, 0, 8, 5, 4'hF);
    req(1, 1, 8, 9, 4'hF);
    chk("rbw_old", bus.read_data, 32'd5);
    req(0, 1, 8, 0, 0);
    chk("rbw_new", bus.read_data, 32'd9);
    req(0, 0, 8, 0, 4'hF);
    chk("noop_err", {31'b0, bus.err}, 32'd0);
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    wait_ready("reclear_cycles");
    req(0, 1, 8, 0, 0);
    chk("reclear_word2", bus.read_data, 32'd0);
    for (int k = 0; k < 3000; k++) begin
      bus.req_valid = ($urandom % 4) != 0;
      bus.mem_read = $urandom % 2;
      bus.mem_write = $urandom % 2;
      bus.addr = ($urandom % 5 == 0) ? ($urandom % 512) : {24'b0, 6'($urandom % 64), 2'b00};
      bus.write_data = $urandom;
      bus.byte_en = 4'($urandom);
      reset = ($urandom % 900) == 0;
      @(posedge clk);
      #1;
    end
    reset = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/data_mem_sync.md
# data_mem_sync

Parametrised, clocked data memory for the single-cycle/pipelined datapath. Accepts one read and/or write request per cycle over a valid/ready handshake with byte addressing. Returns read data with one cycle of latency and flags misaligned or out-of-range accesses. After every reset, a hardware clear sequence zeroes the whole array before the first request is accepted, so no file preload is required.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH, 64, number of words; power of two, ≥2.

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present this cycle
- req_ready  out  1  block can accept a request
- mem_write  in  1  request includes a write
- mem_read  in  1  request includes a read
- addr  in  ADDR_WIDTH  byte address
- write_data  in  DATA_WIDTH  store data
- byte_en  in  DATA_WIDTH/8  per-byte write strobe (see Configuration)
- read_data  out  DATA_WIDTH  load data, registered
- read_valid  out  1  read_data updated this cycle
- err  out  1  one-cycle pulse: accepted request was misaligned or out of range

## Operation
- One clock domain (clk). Reset is synchronous and active-high.
- Accept = req_valid & req_ready & (mem_read | mem_write).
- Constants: LANES = DATA_WIDTH/8, OFF = clog2(LANES), IDX = clog2(DEPTH).
- Word index = addr[OFF +: IDX].
- Misaligned: addr[OFF-1:0] ≠ 0.
- Out of range: any addr bit at or above OFF+IDX is set.
- Bad access (misaligned or out of range), when accepted: no array write, read_valid stays 0, err = 1 next cycle, read_data holds.
- Good write: updates the selected word at the accepting edge.
- Good read: read_data loads the word at the accepting edge, read_valid = 1 for one cycle. read_data holds until the next good read.
- Read and write in the same request: read-before-write. read_data returns the old word; the array takes the new one.
- Request with neither mem_read nor mem_write: ignored, no err.
- FSM states: CLEAR, READY.
  - reset high → CLEAR, clear counter = 0, no array write.
  - CLEAR: each cycle write 0 to mem[counter] and increment the counter. When counter = DEPTH-1, go to READY.
  - READY: stays until reset.
- req_ready = (state == READY), decoded from the state register.
- Requests presented while req_ready = 0 are dropped. Requesters hold them.
- Reset in any state, including mid-clear: state → CLEAR, counter → 0, and the clear restarts from word 0.
- Reset values: req_ready 0, read_data 0, read_valid 0, err 0.

## Timing
- Read latency is 1: request accepted at edge N gives read_data/read_valid valid after edge N (cycle N+1).
- Write is visible to a read accepted at edge N+1 or later.
- Back-to-back requests every cycle are supported. Throughput is 1 per cycle in READY.
- Clear takes exactly DEPTH cycles. req_ready first rises DEPTH edges after the first edge with reset low.
- err and read_valid are single-cycle pulses, never asserted together.

## Configuration
- Macro DATA_MEM_BYTE_WRITE_EN.
  - Defined: good writes update only the byte lanes whose byte_en bit is 1. byte_en = 0 writes nothing but is still checked for err.
  - Undefined: byte_en is ignored and every good write updates the full word.
- The byte_en port exists in both builds.
- Reads always return the full word.

## Structure
- Package data_mem_pkg holds:
  - state enum typedef (CLEAR, READY)
  - helper constants for LANES/OFF/IDX derivation
  - the default DATA_WIDTH/DEPTH values
- One sub-module, data_mem_clear_ctrl: clear FSM, counter, req_ready generation, and the clear-write address/enable.
- Top level holds: array, address decode, error check, byte-lane write mask, read register.

## Test plan
- Reset for 2 cycles, then idle → req_ready 0 for exactly 64 cycles, then 1. A read of word 25 (addr 100) returns 0 with read_valid one cycle later.
- Write 200 to addr 8, then read addr 8 on the next cycle → read_data = 200, read_valid pulse of 1 cycle.
- Byte write with macro defined:
  - word 3 (addr 12) = 0x11223344, then write 0xAABBCCDD with byte_en 4'b0010 → read 0x1122CC44.
  - Same sequence with macro undefined → 0xAABBCCDD.
- addr 6 write 0xFF → err pulse 1 cycle, read_valid 0, word 1 unchanged. addr 256 read → err pulse, read_data holds its previous value.
- Word 2 = 5, then a single request with read+write of 9 to addr 8 → read_data = 5, and the following read → 9.
- Assert reset at clear cycle 30, release → clear restarts: req_ready 0 for 64 further cycles. A previously written word (addr 8) reads 0.
